// File: rtl/network_sequencer.sv
// network_sequencer
//   Rule scheduler and state holder for Boolean network simulation. Holds the
//   network state, presents one rule index per evaluation to an external
//   combinational network-logic block and commits its next-state vector in
//   round-robin, random (LFSR) or snapshot-synchronous order. Counts rounds,
//   detects steady state and reports completion with start/busy/done.
//
// Ports
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   start             begin a run (sampled only in IDLE)
//   mode[1:0]         0 round-robin, 1 random, 2 synchronous, 3 as 0
//   steps[STEP_W]     rounds to run, 0 = until steady
//   init_state[RULES] state loaded on start
//   next_state[RULES] external logic output for (state, rule_idx)
//   state[RULES]      current network state
//   rule_idx          rule under evaluation
//   busy, done        run in progress / one-cycle completion pulse
//   steady            last completed round changed no bit
//   round_count       completed rounds in current or last run
module network_sequencer #(
    parameter int          RULES     = 61,
    parameter int          NUM_IDX   = 38,
    parameter int          LOG_RULES = 6,
    parameter int          LOGIC_LAT = 0,
    parameter int          STEP_W    = 16,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [STEP_W-1:0]    steps,
    input  logic [RULES-1:0]     init_state,
    input  logic [RULES-1:0]     next_state,
    output logic [RULES-1:0]     state,
    output logic [LOG_RULES-1:0] rule_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 steady,
    output logic [STEP_W-1:0]    round_count
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_ROUND, S_DONE} fsm_t;

    localparam logic [LOG_RULES-1:0] LAST_IDX  = (LOG_RULES)'(NUM_IDX - 1);
    localparam logic [LOG_RULES:0]   IDX_LIM   = (LOG_RULES + 1)'(NUM_IDX);
    localparam logic [1:0]           WAIT_LAST = 2'(LOGIC_LAT);

    fsm_t                 r_fsm, w_fsm_nxt;
    logic [RULES-1:0]     r_state, r_acc;
    logic [1:0]           r_mode;
    logic [STEP_W-1:0]    r_steps, r_round;
    logic                 r_steady, r_changed;
    logic [LOG_RULES-1:0] r_cnt;
    logic [1:0]           r_wait;
    logic [15:0]          r_lfsr;

    logic [LOG_RULES-1:0] w_lidx;
    logic                 w_lidx_ok, w_rand, w_reject, w_sample, w_last, w_finish;
    logic [RULES-1:0]     w_diff;
    logic [STEP_W-1:0]    w_round_inc;
    logic [15:0]          w_lfsr_nxt;

    assign w_lidx      = r_lfsr[LOG_RULES-1:0];
    assign w_lidx_ok   = ({1'b0, w_lidx} < IDX_LIM);
    assign w_rand      = (r_mode == 2'd1);
    // Out-of-range random index: burn the cycle, no wait, no sample.
    assign w_reject    = w_rand && !w_lidx_ok;
    assign w_sample    = (r_fsm == S_EVAL) && !w_reject && (r_wait == WAIT_LAST);
    assign w_last      = w_sample && (r_cnt == LAST_IDX);
    assign w_diff      = next_state ^ r_state;
    assign w_round_inc = (&r_round) ? r_round : r_round + STEP_W'(1);
    assign w_finish    = (r_steps != '0) ? (w_round_inc == r_steps)
                                         : (!r_changed || (&w_round_inc));
    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    assign w_lfsr_nxt  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_fsm <= S_IDLE;
        else          r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (start) w_fsm_nxt = S_EVAL;
            S_EVAL:  if (w_last) w_fsm_nxt = S_ROUND;
            S_ROUND: w_fsm_nxt = w_finish ? S_DONE : S_EVAL;
            S_DONE:  w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= '0;
            r_acc     <= '0;
            r_mode    <= 2'd0;
            r_steps   <= '0;
            r_round   <= '0;
            r_steady  <= 1'b0;
            r_changed <= 1'b0;
            r_cnt     <= '0;
            r_wait    <= 2'd0;
            r_lfsr    <= SEED;
        end else begin
            case (r_fsm)
                S_IDLE: if (start) begin
                    r_state   <= init_state;
                    r_mode    <= (mode == 2'd3) ? 2'd0 : mode;
                    r_steps   <= steps;
                    r_round   <= '0;
                    r_steady  <= 1'b0;
                    r_acc     <= '0;
                    r_changed <= 1'b0;
                    r_cnt     <= '0;
                    r_wait    <= 2'd0;
                    r_lfsr    <= SEED;
                end
                S_EVAL: begin
                    if (w_rand && (w_reject || w_sample)) r_lfsr <= w_lfsr_nxt;
                    if (w_reject) begin
                        r_wait <= 2'd0;
                    end else if (w_sample) begin
                        r_wait <= 2'd0;
                        r_cnt  <= r_cnt + LOG_RULES'(1);
                        if (w_diff != '0) r_changed <= 1'b1;
                        // Synchronous mode evaluates every rule against the
                        // snapshot; differences are applied at round end.
                        if (r_mode == 2'd2) r_acc   <= r_acc | w_diff;
                        else                r_state <= next_state;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                S_ROUND: begin
                    if (r_mode == 2'd2) r_state <= r_state ^ r_acc;
                    r_round  <= w_round_inc;
                    r_steady <= ~r_changed;
                    if (!w_finish) begin
                        r_acc     <= '0;
                        r_changed <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rule_idx = '0;
        if (r_fsm == S_EVAL) begin
            if (w_rand) rule_idx = w_lidx_ok ? w_lidx : '0;
            else        rule_idx = r_cnt;
        end
    end

    assign state       = r_state;
    assign busy        = (r_fsm == S_EVAL) || (r_fsm == S_ROUND);
    assign done        = (r_fsm == S_DONE);
    assign steady      = r_steady;
    assign round_count = r_round;

endmodule

// File: tb/tb_network_sequencer.sv
// Bench for network_sequencer on a 4-bit ring network (rule i: bit i <= bit i-1).
// Three instances: A (NUM_IDX=4, LAT=0), B (NUM_IDX=3, LAT=0), C (NUM_IDX=4, LAT=2).
module tb_network_sequencer;
    localparam int NIDX [3] = '{4, 3, 4};
    localparam int LAT  [3] = '{0, 0, 2};
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int         who;
        logic [3:0] st;
        int         rc;
        bit         stdy;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic [15:0] steps;
    logic [3:0]  init;
    logic [2:0]  start_v;
    logic [3:0]  nxt [3];
    logic [3:0]  st  [3];
    logic [1:0]  idx [3];
    logic [2:0]  busy_v, done_v, stdy_v;
    logic [15:0] rc  [3];

    exp_t expq[$];
    int   trace[$];
    exp_t last_e;
    bit   have_last = 1'b0;
    int   checks = 0, failures = 0;
    int   ndone [3] = '{0, 0, 0};
    int   bcnt  [3] = '{0, 0, 0};
    bit   chk_trace = 1'b1, zero_chk = 1'b0, hold_chk = 1'b0, final_chk = 1'b0;
    int   n_to = 0, seen_to = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] ring(input logic [3:0] s, input int i);
        logic [3:0] r;
        r = s;
        r[i] = s[(i + 3) % 4];
        return r;
    endfunction

    assign nxt[0] = ring(st[0], int'(idx[0]));
    assign nxt[1] = ring(st[1], int'(idx[1]));
    assign nxt[2] = ring(st[2], int'(idx[2]));

    network_sequencer #(.RULES(4), .NUM_IDX(4), .LOG_RULES(2), .LOGIC_LAT(0), .STEP_W(16)) u_a (
        .clk(clk), .reset_n(rst_n), .start(start_v[0]), .mode(mode), .steps(steps),
        .init_state(init), .next_state(nxt[0]), .state(st[0]), .rule_idx(idx[0]),
        .busy(busy_v[0]), .done(done_v[0]), .steady(stdy_v[0]), .round_count(rc[0]));

    network_sequencer #(.RULES(4), .NUM_IDX(3), .LOG_RULES(2), .LOGIC_LAT(0), .STEP_W(16)) u_b (
        .clk(clk), .reset_n(rst_n), .start(start_v[1]), .mode(mode), .steps(steps),
        .init_state(init), .next_state(nxt[1]), .state(st[1]), .rule_idx(idx[1]),
        .busy(busy_v[1]), .done(done_v[1]), .steady(stdy_v[1]), .round_count(rc[1]));

    network_sequencer #(.RULES(4), .NUM_IDX(4), .LOG_RULES(2), .LOGIC_LAT(2), .STEP_W(16)) u_c (
        .clk(clk), .reset_n(rst_n), .start(start_v[2]), .mode(mode), .steps(steps),
        .init_state(init), .next_state(nxt[2]), .state(st[2]), .rule_idx(idx[2]),
        .busy(busy_v[2]), .done(done_v[2]), .steady(stdy_v[2]), .round_count(rc[2]));

    task automatic chk(input string nm, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] r;
        r = l >> 1;
        if (l[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Reference model: whole run at rule level. Pushes the final result and
    // the per-busy-cycle expected rule index (-1 = not checked).
    task automatic model(input int w, input int md_in, input int stp, input logic [3:0] ini);
        exp_t e;
        logic [3:0] s, acc, nx;
        logic [15:0] lf;
        int md, rcnt, cyc, napp, ix;
        bit chg;
        md = (md_in == 3) ? 0 : md_in;
        s = ini; rcnt = 0; cyc = 0; lf = SEED; chg = 1'b0;
        forever begin
            acc = 4'b0; chg = 1'b0; napp = 0;
            while (napp < NIDX[w]) begin
                if (md == 1) begin
                    ix = int'(lf[1:0]);
                    lf = lfsr_step(lf);
                    if (ix >= NIDX[w]) begin
                        trace.push_back(-1);
                        cyc++;
                        continue;
                    end
                end else begin
                    ix = napp;
                end
                repeat (LAT[w] + 1) begin
                    trace.push_back(ix);
                    cyc++;
                end
                nx = ring(s, ix);
                if (nx != s) chg = 1'b1;
                if (md == 2) acc = acc | (nx ^ s);
                else         s = nx;
                napp++;
            end
            trace.push_back(-1);
            cyc++;
            if (md == 2) s = s ^ acc;
            rcnt++;
            if (stp != 0 ? (rcnt == stp) : !chg) break;
        end
        e.who = w; e.st = s; e.rc = rcnt; e.stdy = !chg; e.cyc = cyc;
        expq.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        int t;
        exp_t e;
        if (n_to != seen_to) begin
            seen_to = n_to;
            chk("wait_done_timeout", 1, 0);
        end
        if (zero_chk) begin
            for (int w = 0; w < 3; w++) begin
                chk("zero_state", st[w], 0);
                chk("zero_rule_idx", idx[w], 0);
                chk("zero_busy", busy_v[w], 0);
                chk("zero_done", done_v[w], 0);
                chk("zero_steady", stdy_v[w], 0);
                chk("zero_round_count", rc[w], 0);
            end
        end
        if (hold_chk && have_last) begin
            chk("hold_state", st[last_e.who], last_e.st);
            chk("hold_round_count", rc[last_e.who], last_e.rc);
            chk("hold_steady", stdy_v[last_e.who], last_e.stdy);
        end
        if (final_chk) begin
            chk("pending_results", expq.size(), 0);
            chk("pending_trace", trace.size(), 0);
        end
        if (!rst_n) begin
            for (int w = 0; w < 3; w++) bcnt[w] = 0;
        end else begin
            for (int w = 0; w < 3; w++) begin
                if (busy_v[w]) begin
                    bcnt[w]++;
                    if (done_v[w]) chk("busy_done_overlap", 1, 0);
                    chk("rule_idx_range", (int'(idx[w]) < NIDX[w]) ? 1 : 0, 1);
                    if (chk_trace) begin
                        if (trace.size() == 0) chk("unexpected_busy", 1, 0);
                        else begin
                            t = trace.pop_front();
                            if (t >= 0) chk("rule_idx", idx[w], t);
                        end
                    end
                end
                if (done_v[w]) begin
                    ndone[w]++;
                    if (expq.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        e = expq.pop_front();
                        chk("done_instance", w, e.who);
                        chk("final_state", st[w], e.st);
                        chk("round_count", rc[w], e.rc);
                        chk("steady", stdy_v[w], e.stdy);
                        chk("busy_cycles", bcnt[w], e.cyc);
                        last_e = e;
                        have_last = 1'b1;
                    end
                    bcnt[w] = 0;
                end
            end
        end
    end

    task automatic drive_start(input int w, input int md, input int stp, input logic [3:0] ini);
        mode = md[1:0]; steps = stp[15:0]; init = ini;
        start_v[w] = 1'b1;
        @(posedge clk); #1;
        start_v[w] = 1'b0;
    endtask

    task automatic wait_done(input int w, input int d0);
        bit ok;
        ok = 1'b0;
        repeat (3000) begin
            @(posedge clk); #1;
            if (ndone[w] != d0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_to++;
            expq.delete();
            trace.delete();
        end
    endtask

    task automatic run(input int w, input int md, input int stp, input logic [3:0] ini);
        int d0;
        d0 = ndone[w];
        model(w, md, stp, ini);
        drive_start(w, md, stp, ini);
        wait_done(w, d0);
    endtask

    initial begin
        int w, md, stp, d0;
        bit seen;
        rst_n = 1'b0; start_v = 3'b0; mode = 2'd0; steps = 16'd0; init = 4'd0;
        zero_chk = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1 zero_chk = 1'b0;

        run(0, 0, 1, 4'b1000);
        run(0, 0, 0, 4'b1000);
        run(0, 2, 1, 4'b1000);
        run(0, 2, 2, 4'b1000);
        run(0, 2, 3, 4'b1000);
        run(0, 3, 1, 4'b0100);
        run(1, 1, 2, 4'b1010);
        run(2, 0, 1, 4'b1000);

        // start while busy and during the done cycle must be ignored
        d0 = ndone[0];
        model(0, 0, 2, 4'b0110);
        drive_start(0, 0, 2, 4'b0110);
        repeat (3) begin @(posedge clk); #1; end
        drive_start(0, 2, 1, 4'b0001);
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
            if (done_v[0]) begin
                seen = 1'b1;
                start_v[0] = 1'b1;
                @(posedge clk); #1;
                start_v[0] = 1'b0;
                break;
            end
        end
        if (!seen) begin n_to++; expq.delete(); trace.delete(); end
        repeat (20) begin @(posedge clk); #1; end
        hold_chk = 1'b1;
        @(posedge clk); #1 hold_chk = 1'b0;

        // reset mid-run on C: outputs clear and no done follows
        chk_trace = 1'b0;
        drive_start(2, 0, 3, 4'b1000);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0; zero_chk = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        zero_chk = 1'b0;
        repeat (60) begin @(posedge clk); #1; end
        chk_trace = 1'b1;

        for (int i = 0; i < 14; i++) begin
            w = $urandom_range(0, 2);
            if (w == 1) md = 1;
            else        md = $urandom_range(0, 3);
            if (md == 0 || md == 3) stp = $urandom_range(0, 4);
            else                    stp = $urandom_range(1, 4);
            run(w, md, stp, 4'($urandom));
        end

        final_chk = 1'b1;
        @(posedge clk); #1 final_chk = 1'b0;
        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/network_sequencer.md
# network_sequencer

Parametrised rule scheduler and state holder for Boolean network simulation. It owns the network state register and drives a rule index into an external combinational network-logic block, one rule per evaluation. It commits that block's next-state vector under one of three update modes: round-robin asynchronous, random asynchronous, or snapshot-synchronous. It counts rounds, detects steady state, and reports completion through a start/busy/done handshake.

## Interface
Parameters:
- RULES, 61: width of the network state vector.
- NUM_IDX, 38: number of rule indices applied per round, indices 0..NUM_IDX-1.
- LOG_RULES, 6: rule-index width; 2^LOG_RULES >= NUM_IDX.
- LOGIC_LAT, 0: wait cycles between driving rule_idx and sampling next_state (0..3).
- STEP_W, 16: width of the round count and round limit.
- SEED, 16'hACE1: nonzero 16-bit LFSR seed.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- mode  in  2  0 round-robin, 1 random, 2 synchronous, 3 treated as 0; latched on start.
- steps  in  STEP_W  rounds to run; 0 means run until steady; latched on start.
- init_state  in  RULES  state loaded on start.
- next_state  in  RULES  output of the external logic for (state, rule_idx).
- state  out  RULES  current network state; drives the logic's current_state.
- rule_idx  out  LOG_RULES  rule under evaluation.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of run.
- steady  out  1  last completed round changed no bit; held until next start.
- round_count  out  STEP_W  completed rounds in the current or last run.

## Operation
- Reset values: all outputs 0, FSM IDLE, LFSR = SEED, accumulator and changed flag cleared. Reset mid-run aborts the run without asserting done.
- FSM states are IDLE, EVAL, ROUND and DONE.
- IDLE: on start, load state←init_state, latch mode/steps, clear round_count, steady, acc, changed and pointer, reseed LFSR←SEED, then go to EVAL. start is ignored when not in IDLE.
- EVAL: rule_idx is held for LOGIC_LAT wait cycles. On the sample cycle, changed |= (next_state != state).
  - Modes 0/1: state←next_state.
  - Mode 2: acc |= next_state ^ state, and state is unchanged.
  - Each accepted sample increments the apply counter. After NUM_IDX accepted samples, go to ROUND.
- Mode 0: rule_idx = apply counter (0,1,…,NUM_IDX-1).
- Mode 1: rule_idx = lfsr[LOG_RULES-1:0].
  - The LFSR is a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, and advances once per sample cycle.
  - An index >= NUM_IDX is rejected: the LFSR advances, nothing is sampled or counted, and the cycle is spent.
  - With LOGIC_LAT>0, the wait restarts on each new index.
- ROUND, one cycle:
  - Mode 2: state←state^acc.
  - round_count←round_count+1 (saturating), steady←~changed.
  - Exit to DONE if steps!=0 and the new count equals steps, or if steps==0 and ~changed, or if steps==0 and the new count is all-ones. In the all-ones case steady reflects the final round.
  - Otherwise clear acc, changed and the apply counter, then return to EVAL.
- DONE: done=1 for one cycle, busy=0, then IDLE. state, steady and round_count hold.
- Mode 2 relies on each rule writing only its own state bits, so XOR-difference accumulation is exact.

## Timing
- start sampled at edge k: busy=1 from cycle k+1.
- Mode 0/2, LOGIC_LAT=L: each round takes NUM_IDX·(L+1) EVAL cycles plus 1 ROUND cycle.
- steps=1, L=0: EVAL cycles k+1..k+NUM_IDX, ROUND at k+NUM_IDX+1, done at k+NUM_IDX+2.
- next_state is sampled at the end of the last wait cycle. rule_idx and state are stable throughout the wait.
- done and busy are never high together. A start coinciding with done is ignored; the earliest accepted start is in the cycle after done.

## Test plan
Bench uses a toy ring network with RULES=4 and NUM_IDX=4, where rule i sets bit i = bit (i-1 mod 4).
- Mode 0, steps=1, init 4'b1000 -> state 4'b1111, round_count=1, done at start+6 cycles, steady=0.
- Mode 0, steps=0, init 4'b1000 -> done after round 2, state 4'b1111, steady=1, round_count=2.
- Mode 2, steps=3, init 4'b1000 -> state 4'b0001 after round 1, 4'b0010 after round 2, final 4'b0100, steady=0.
- Mode 1, NUM_IDX=3, steps=2 -> rule_idx never equals 3. The index sequence matches the reference-model LFSR from SEED, and exactly 6 samples are accepted.
- LOGIC_LAT=2, mode 0, steps=1 -> each rule_idx is held 3 cycles and the result matches the first test; reset_n pulsed mid-run -> all outputs 0 and no done pulse.
- start pulsed while busy and in the done cycle -> ignored, so round_count and state are unaffected.
